// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Instruction-sequencing control unit for the 8-bit practical processor.
// Steps through START -> FETCH -> DECODE -> EXEC (-> FETCH ...) and drives the
// datapath load/select strobes from the registered state and the opcode held
// in IR[7:5]. Opcode 111 parks the machine in HALT until Reset.
//
// Optional feature (compile-time macro CU_INPUT_WAIT_EN):
//   defined   : the INPUT instruction holds in EXEC until Enter is seen high,
//               loading the accumulator only in that cycle.
//   undefined : INPUT completes in a single EXEC cycle and Enter is ignored.
//
// Parameters:
//   OPW      opcode width, taken from the top of IR (default 3 -> IR[7:5])
//
// Ports:
//   Clock    in   system clock, rising edge active
//   Reset    in   synchronous active-high reset, forces START
//   IR       in   instruction register [7:5] opcode, [4:0] address
//   Aeq0     in   accumulator == 0 flag (looked at in EXEC only)
//   Apos     in   accumulator > 0 flag (looked at in EXEC only)
//   Enter    in   user input-ready strobe (CU_INPUT_WAIT_EN builds only)
//   IRload   out  load IR from memory
//   PCload   out  load PC
//   JMPmux   out  PC source: 1 = IR[4:0], 0 = PC+1
//   Meminst  out  memory address source: 1 = PC, 0 = IR[4:0]
//   MemWr    out  memory write enable
//   Asel     out  accumulator source: 00 ALU, 01 external input, 10 memory
//   Aload    out  load accumulator
//   Sub      out  ALU op: 1 = subtract, 0 = add
//   Halt     out  processor halted
//   State    out  current state encoding (debug)
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int OPW = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
  output logic       IRload,
  output logic       PCload,
  output logic       JMPmux,
  output logic       Meminst,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       Sub,
  output logic       Halt,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    START  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [OPW-1:0] OP_LOAD  = OPW'(0);
  localparam logic [OPW-1:0] OP_STORE = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(3);
  localparam logic [OPW-1:0] OP_INPUT = OPW'(4);
  localparam logic [OPW-1:0] OP_JZ    = OPW'(5);
  localparam logic [OPW-1:0] OP_JPOS  = OPW'(6);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(7);

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  state_t         state_q;
  state_t         state_n;
  logic [OPW-1:0] opcode;

  assign opcode = IR[7 -: OPW];
  assign State  = state_q;

  // The address field only feeds the datapath; it is not decoded here.
  logic unused_addr;
  assign unused_addr = ^IR[7-OPW:0];

`ifndef CU_INPUT_WAIT_EN
  logic unused_enter;
  assign unused_enter = Enter;
`endif

  // State register: Reset wins over any pending transition, including HALT
  // and an INPUT wait.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= START;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state and Moore/Mealy outputs. Everything defaults to 0 so that each
  // state only names the strobes it raises.
  always_comb begin
    state_n = START;
    IRload  = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = ASEL_ALU;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Halt    = 1'b0;

    unique case (state_q)
      START: begin
        state_n = FETCH;
      end

      FETCH: begin
        // Read the instruction at PC into IR and step PC to PC+1.
        IRload  = 1'b1;
        PCload  = 1'b1;
        JMPmux  = 1'b0;
        Meminst = 1'b1;
        state_n = DECODE;
      end

      DECODE: begin
        // Meminst=0 already presents the operand address so EXEC sees valid
        // memory data for LOAD.
        Meminst = 1'b0;
        state_n = (opcode == OP_HALT) ? HALT : EXEC;
      end

      EXEC: begin
        state_n = FETCH;
        case (opcode)
          OP_LOAD: begin
            Asel  = ASEL_MEM;
            Aload = 1'b1;
          end
          OP_STORE: begin
            MemWr = 1'b1;
          end
          OP_ADD: begin
            Asel  = ASEL_ALU;
            Sub   = 1'b0;
            Aload = 1'b1;
          end
          OP_SUB: begin
            Asel  = ASEL_ALU;
            Sub   = 1'b1;
            Aload = 1'b1;
          end
          OP_INPUT: begin
`ifdef CU_INPUT_WAIT_EN
            // Park in EXEC until the user strobes Enter; no timeout.
            if (Enter) begin
              Asel  = ASEL_IN;
              Aload = 1'b1;
            end else begin
              state_n = EXEC;
            end
`else
            Asel  = ASEL_IN;
            Aload = 1'b1;
`endif
          end
          OP_JZ: begin
            if (Aeq0) begin
              JMPmux = 1'b1;
              PCload = 1'b1;
            end
          end
          OP_JPOS: begin
            if (Apos) begin
              JMPmux = 1'b1;
              PCload = 1'b1;
            end
          end
          default: begin
            // HALT opcode never reaches EXEC; treat defensively as a no-op.
          end
        endcase
      end

      HALT: begin
        Halt    = 1'b1;
        state_n = HALT;
      end

      default: begin
        // Encodings 5-7 recover to START with all strobes low.
        state_n = START;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Self-checking bench for control_unit. Each cycle the expected output vector
// is pushed to a scoreboard queue when the stimulus is driven and popped and
// compared on the following falling edge. Expected vectors are built from the
// instruction behaviour table of the control unit, independent of the RTL.
// Follows CU_INPUT_WAIT_EN so the INPUT checks match the build under test.
// -----------------------------------------------------------------------------
module tb_control_unit;

  logic       Clock;
  logic       Reset;
  logic [7:0] IR;
  logic       Aeq0;
  logic       Apos;
  logic       Enter;
  logic       IRload;
  logic       PCload;
  logic       JMPmux;
  logic       Meminst;
  logic       MemWr;
  logic [1:0] Asel;
  logic       Aload;
  logic       Sub;
  logic       Halt;
  logic [2:0] State;

  control_unit #(.OPW(3)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .IR      (IR),
    .Aeq0    (Aeq0),
    .Apos    (Apos),
    .Enter   (Enter),
    .IRload  (IRload),
    .PCload  (PCload),
    .JMPmux  (JMPmux),
    .Meminst (Meminst),
    .MemWr   (MemWr),
    .Asel    (Asel),
    .Aload   (Aload),
    .Sub     (Sub),
    .Halt    (Halt),
    .State   (State)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Packed view of all outputs: state, IRload, PCload, JMPmux, Meminst,
  // MemWr, Asel, Aload, Sub, Halt.
  typedef logic [13:0] out_t;

  out_t obs;
  assign obs = {State, IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub, Halt};

  function automatic out_t mk(input logic [2:0] st, input logic irl, input logic pcl,
                              input logic jmp, input logic mi, input logic mw,
                              input logic [1:0] asel, input logic al, input logic sb,
                              input logic hl);
    return {st, irl, pcl, jmp, mi, mw, asel, al, sb, hl};
  endfunction

  out_t E_START, E_FETCH, E_DECODE, E_HALT;
  out_t E_LOAD, E_STORE, E_ADD, E_SUB, E_INPUT, E_JMP, E_NOJMP, E_WAIT;

  out_t exp_q[$];
  out_t got;
  out_t e;
  int   tests_run;
  int   tests_failed;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) tick();
    exp_q.push_back(E_START);
    Reset = 1'b0;
    @(negedge Clock);
    got = obs; e = exp_q.pop_front(); tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL reset_start: got %h expected %h", got, e);
    end
    tick();
  endtask

  // LOAD, ADD, STORE, SUB back to back; each takes FETCH/DECODE/EXEC.
  task automatic test_alu_mem();
    logic [7:0] irs  [4] = '{8'b000_00011, 8'b010_00100, 8'b001_00001, 8'b011_00010};
    out_t       exs  [4];
    exs = '{E_LOAD, E_ADD, E_STORE, E_SUB};
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (c == 0) IR = irs[i];
        exp_q.push_back(c == 0 ? E_FETCH : (c == 1 ? E_DECODE : exs[i]));
        @(negedge Clock);
        got = obs; e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin
          tests_failed++;
          $display("FAIL alu_mem instr%0d cyc%0d: got %h expected %h", i, c, got, e);
        end
        tick();
      end
    end
  endtask

  // JZ/JPOS taken and not taken; flags hold the opposite value outside EXEC.
  task automatic test_jumps();
    logic [7:0] irs [4] = '{8'b101_01010, 8'b101_01010, 8'b110_00111, 8'b110_00111};
    logic       flg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (c == 0) IR = irs[i];
        if (c < 2) begin
          Aeq0 = ~flg[i];
          Apos = ~flg[i];
        end else begin
          Aeq0 = (i < 2) ? flg[i] : ~flg[i];
          Apos = (i < 2) ? ~flg[i] : flg[i];
        end
        exp_q.push_back(c == 0 ? E_FETCH : (c == 1 ? E_DECODE : (flg[i] ? E_JMP : E_NOJMP)));
        @(negedge Clock);
        got = obs; e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin
          tests_failed++;
          $display("FAIL jump instr%0d cyc%0d: got %h expected %h", i, c, got, e);
        end
        tick();
      end
    end
    Aeq0 = 1'b0;
    Apos = 1'b0;
  endtask

  // STORE interrupted by Reset during its EXEC cycle.
  task automatic test_reset_exec();
    IR = 8'b001_00101;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) Reset = 1'b1;
      if (c == 3) Reset = 1'b0;
      exp_q.push_back(c == 0 ? E_FETCH : (c == 1 ? E_DECODE : (c == 2 ? E_STORE : E_START)));
      @(negedge Clock);
      got = obs; e = exp_q.pop_front(); tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL reset_exec cyc%0d: got %h expected %h", c, got, e);
      end
      tick();
    end
  endtask

  task automatic test_input();
`ifdef CU_INPUT_WAIT_EN
    // 0,1: FETCH/DECODE with Enter high (ignored); 2..6 wait with Enter=0;
    // 7 Enter=1 -> load; then a second INPUT reset out of its wait.
    IR = 8'b100_00000;
    for (int c = 0; c < 8; c++) begin
      Enter = (c < 2 || c == 7);
      exp_q.push_back(c == 0 ? E_FETCH : (c == 1 ? E_DECODE : (c == 7 ? E_INPUT : E_WAIT)));
      @(negedge Clock);
      got = obs; e = exp_q.pop_front(); tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL input_wait cyc%0d: got %h expected %h", c, got, e);
      end
      tick();
    end
    Enter = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) Reset = 1'b1;
      if (c == 5) Reset = 1'b0;
      exp_q.push_back(c == 0 ? E_FETCH : (c == 1 ? E_DECODE : (c == 5 ? E_START : E_WAIT)));
      @(negedge Clock);
      got = obs; e = exp_q.pop_front(); tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL input_reset cyc%0d: got %h expected %h", c, got, e);
      end
      tick();
    end
`else
    // INPUT twice: Enter low, then Enter high; both finish in one EXEC.
    IR = 8'b100_00000;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 3; c++) begin
        Enter = (i == 1);
        exp_q.push_back(c == 0 ? E_FETCH : (c == 1 ? E_DECODE : E_INPUT));
        @(negedge Clock);
        got = obs; e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin
          tests_failed++;
          $display("FAIL input instr%0d cyc%0d: got %h expected %h", i, c, got, e);
        end
        tick();
      end
    end
    Enter = 1'b0;
`endif
  endtask

  // HALT held 10 cycles with noisy inputs, Reset pulse, then a LOAD resumes.
  task automatic test_halt();
    IR = 8'b111_00000;
    for (int c = 0; c < 16; c++) begin
      Aeq0  = c[0];
      Apos  = c[1];
      Enter = c[0];
      if (c == 12) Reset = 1'b1;
      if (c == 13) begin
        Reset = 1'b0;
        IR    = 8'b000_00001;
        Enter = 1'b0;
      end
      if (c < 13)
        exp_q.push_back(c == 0 ? E_FETCH : (c == 1 ? E_DECODE : E_HALT));
      else
        exp_q.push_back(c == 13 ? E_START : (c == 14 ? E_FETCH : E_DECODE));
      @(negedge Clock);
      got = obs; e = exp_q.pop_front(); tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL halt cyc%0d: got %h expected %h", c, got, e);
      end
      tick();
    end
    exp_q.push_back(E_LOAD);
    @(negedge Clock);
    got = obs; e = exp_q.pop_front(); tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL halt_resume_load: got %h expected %h", got, e);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset = 1'b1;
    IR    = 8'h00;
    Aeq0  = 1'b0;
    Apos  = 1'b0;
    Enter = 1'b0;

    E_START  = mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    E_FETCH  = mk(3'd1, 1, 1, 0, 1, 0, 2'b00, 0, 0, 0);
    E_DECODE = mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    E_HALT   = mk(3'd4, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    E_LOAD   = mk(3'd3, 0, 0, 0, 0, 0, 2'b10, 1, 0, 0);
    E_STORE  = mk(3'd3, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0);
    E_ADD    = mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
    E_SUB    = mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0);
    E_INPUT  = mk(3'd3, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0);
    E_JMP    = mk(3'd3, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0);
    E_NOJMP  = mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    E_WAIT   = mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);

    test_reset();
    test_alu_mem();
    test_jumps();
    test_reset_exec();
    test_input();
    test_halt();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing control unit for the 8-bit practical processor. It reads the opcode held in the 8-bit instruction register (IR) and cycles through fetch, decode and execute states. In each state it drives the datapath load and select strobes, including `IRload`, which writes the IR. It sits between the IR/status flags and the datapath registers, PC, ALU and memory.

## Interface
Parameters:
- `OPW`, 3: opcode width, taken from `IR[7:5]`.

Ports:
- `Clock` in 1: system clock; all state changes on the rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `IR` in 8: instruction register contents; `IR[7:5]` is the opcode, `IR[4:0]` is the address (used by the datapath only).
- `Aeq0` in 1: accumulator-is-zero flag.
- `Apos` in 1: accumulator-is-positive flag (bit 7 = 0 and value nonzero).
- `Enter` in 1: user input-ready strobe; used only when `CU_INPUT_WAIT_EN` is defined.
- `IRload` out 1: load IR from memory.
- `PCload` out 1: load PC (increment, or jump target when `JMPmux`=1).
- `JMPmux` out 1: PC source select; 1 = `IR[4:0]`, 0 = PC+1.
- `Meminst` out 1: memory address select; 1 = PC, 0 = `IR[4:0]`.
- `MemWr` out 1: memory write enable.
- `Asel` out 2: accumulator input select; 00 = ALU, 01 = external input, 10 = memory data.
- `Aload` out 1: load accumulator.
- `Sub` out 1: ALU operation; 1 = subtract, 0 = add.
- `Halt` out 1: processor halted.
- `State` out 3: current state encoding, for debug.

## Operation
- States and encodings: START=0, FETCH=1, DECODE=2, EXEC=3, HALT=4. Encodings 5–7 are illegal and go to START.
- Transitions:
  - START→FETCH.
  - FETCH→DECODE.
  - DECODE→EXEC, except opcode 111 goes to HALT.
  - EXEC→FETCH.
  - HALT→HALT until `Reset`.
- Outputs are combinational from the registered state and `IR[7:5]`. Any output not listed below is 0.
- START: all outputs 0.
- FETCH: `IRload`=1, `PCload`=1, `JMPmux`=0, `Meminst`=1.
- DECODE: `Meminst`=0 (presents the operand address); no loads.
- EXEC, by opcode:
  - 000 LOAD: `Asel`=10, `Aload`=1.
  - 001 STORE: `MemWr`=1.
  - 010 ADD: `Asel`=00, `Sub`=0, `Aload`=1.
  - 011 SUB: `Asel`=00, `Sub`=1, `Aload`=1.
  - 100 INPUT: `Asel`=01, `Aload`=1 (see Configuration).
  - 101 JZ: if `Aeq0`, `JMPmux`=1 and `PCload`=1; otherwise no load.
  - 110 JPOS: if `Apos`, `JMPmux`=1 and `PCload`=1; otherwise no load.
- HALT: `Halt`=1; all other outputs 0.
- `Aeq0` and `Apos` are sampled combinationally during EXEC only. Flag changes in any other state have no effect.

## Timing
- Reset values:
  - `Reset` high at a rising edge forces START on that edge.
  - All outputs are 0 while in START; `State`=0.
- Reset mid-operation (any state, including HALT, or EXEC waiting on INPUT) gives START on the next edge. An in-progress `MemWr` or `Aload` is dropped after that edge.
- First FETCH occurs in the cycle after `Reset` deasserts.
- Instruction latency: 3 cycles per instruction (FETCH, DECODE, EXEC), excluding any INPUT wait.
- `IRload` in FETCH writes the IR on the FETCH→DECODE edge, so DECODE and EXEC see the new opcode.
- `MemWr` is high for exactly one cycle per STORE.

## Configuration
- Macro: `CU_INPUT_WAIT_EN`.
- Defined: INPUT holds in EXEC with `Aload`=0 while `Enter`=0. In the first EXEC cycle with `Enter`=1, `Aload`=1 and the next state is FETCH. The waiting period has no timeout.
  - `Reset` during the wait returns to START.
  - `Enter` has no effect in any other state or for any other opcode.
- Undefined: INPUT completes in one EXEC cycle with `Aload`=1, and `Enter` is ignored.

## Test plan
- Reset: assert `Reset` for 2 cycles, then release → `State`=0 with all outputs 0. Next cycle `State`=1 with `IRload`=`PCload`=`Meminst`=1.
- LOAD then ADD: `IR`=000_00011, then `IR`=010_00100 → EXEC cycles show `Asel`=10/`Aload`=1, then `Asel`=00/`Sub`=0/`Aload`=1. Each instruction takes 3 cycles.
- JZ: `IR`=101_01010 with `Aeq0`=1 → EXEC `JMPmux`=1, `PCload`=1. Repeat with `Aeq0`=0 → EXEC `PCload`=0.
- HALT plus mid-operation reset: `IR`=111_00000 → `State`=4 and `Halt`=1 held for 10 cycles. Pulse `Reset` → `State`=0 and `Halt`=0 on the next edge.
- INPUT with `CU_INPUT_WAIT_EN` defined: `IR`=100_00000 with `Enter`=0 for 5 cycles → stays in EXEC with `Aload`=0. `Enter`=1 → one cycle of `Asel`=01/`Aload`=1, then FETCH.
- INPUT with the macro undefined: same stimulus → `Aload`=1 in the first EXEC cycle, then FETCH regardless of `Enter`.
